ahb3lite_rr_master: RTL and testbench

AHB3LITE_RR_MASTER -- requirements
Module: ahb3lite_rr_master

---
 rtl/ahb3lite_rr_master.sv | 149 ++++++++++++++
 tb/tb_ahb3lite_rr_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_rr_master.sv
// ahb3lite_rr_master
//   Two-requester round-robin front end for a single AHB-Lite master port.
//   At most one transfer is outstanding: IDLE -> ADDR -> DATA -> IDLE.
//
//   Optional build macro: AHB_RR_HRESP_EN
//     defined   : rsp_err registers HRESP at the data-phase completion edge
//     undefined : HRESP is ignored and rsp_err is tied to 0
//
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   reqN_valid/addr/write/wdata   request from requester N (N = 0,1)
//   reqN_ready              request accepted (combinational, IDLE only)
//   rspN_valid              one-cycle completion pulse to requester N
//   rsp_rdata, rsp_err      shared response data / error status
//   HSEL..HWDATA            AHB-Lite master outputs
//   HRDATA, HREADY, HRESP   AHB-Lite slave responses
module ahb3lite_rr_master #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,

  input  logic                  req0_valid,
  input  logic [HADDR_SIZE-1:0] req0_addr,
  input  logic                  req0_write,
  input  logic [HDATA_SIZE-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,

  input  logic                  req1_valid,
  input  logic [HADDR_SIZE-1:0] req1_addr,
  input  logic                  req1_write,
  input  logic [HDATA_SIZE-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,

  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,

  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [HDATA_SIZE-1:0] HWDATA,

  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t                state;
  logic                  last_grant;  // requester granted most recently
  logic                  grant;       // requester owning the current transfer
  logic                  pick1;       // requester 1 wins arbitration this cycle
  logic [HDATA_SIZE-1:0] wdata_q;

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;

  // Lone request wins; on a tie the requester not granted last wins.
  always_comb begin
    pick1      = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == ST_IDLE) && req0_valid && !pick1;
    req1_ready = (state == ST_IDLE) && pick1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wdata_q    <= '0;
      HSEL       <= 1'b0;
      HTRANS     <= TRANS_IDLE;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HWDATA     <= '0;
      rsp_rdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifdef AHB_RR_HRESP_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            grant      <= pick1;
            last_grant <= pick1;
            HADDR      <= pick1 ? {req1_addr[HADDR_SIZE-1:2], 2'b00}
                                : {req0_addr[HADDR_SIZE-1:2], 2'b00};
            HWRITE     <= pick1 ? req1_write : req0_write;
            wdata_q    <= pick1 ? req1_wdata : req0_wdata;
            HSEL       <= 1'b1;
            HTRANS     <= TRANS_NONSEQ;
            state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HSEL   <= 1'b0;
            HTRANS <= TRANS_IDLE;
            if (HWRITE) HWDATA <= wdata_q;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            if (!HWRITE) rsp_rdata <= HRDATA;
            if (grant) rsp1_valid <= 1'b1;
            else       rsp0_valid <= 1'b1;
`ifdef AHB_RR_HRESP_EN
            rsp_err <= HRESP;
`endif
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address bits [1:0] are forced to zero on capture and never read.
`ifdef AHB_RR_HRESP_EN
  logic unused_bits;
  assign unused_bits = ^{req0_addr[1:0], req1_addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{req0_addr[1:0], req1_addr[1:0], HRESP};
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb3lite_rr_master.sv
module tb_ahb3lite_rr_master;

`ifdef AHB_RR_HRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req0_valid = 1'b0, req0_write = 1'b0, req0_ready, rsp0_valid;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0, req1_ready, rsp1_valid;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  ahb3lite_rr_master #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_write(req0_write),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          n;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          n;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned wa;
    int unsigned wd;
    bit          resp;
    logic [31:0] exp_rdata;
    logic [31:0] exp_haddr;
  } vec_t;

  logic [31:0] mem [int unsigned];
  logic [31:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Scoreboard side: completion pulses pop the oldest expected response.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      chk("both_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp0=%b rsp1=%b expected none", rsp0_valid, rsp1_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_both", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
          chk("rsp_who", rsp1_valid ? 32'd1 : 32'd0, e.n);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [31:0] hw;
    if (v.n == 0) begin
      req0_valid = 1'b1; req0_addr = v.addr; req0_write = v.wr; req0_wdata = v.wdata;
    end else begin
      req1_valid = 1'b1; req1_addr = v.addr; req1_write = v.wr; req1_wdata = v.wdata;
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    #1;
    chk("ready_win",  {31'b0, (v.n == 0) ? req0_ready : req1_ready}, 32'd1);
    chk("ready_lose", {31'b0, (v.n == 0) ? req1_ready : req0_ready}, 32'd0);
    if (!v.wr) model_rdata = v.exp_rdata;
    e.n = v.n; e.rdata = model_rdata; e.err = v.resp & ERR_EN;
    sb.push_back(e);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("addr_htrans", {30'b0, HTRANS}, 32'd2);
    chk("addr_hsel",   {31'b0, HSEL}, 32'd1);
    chk("addr_haddr",  HADDR, v.exp_haddr);
    chk("addr_hwrite", {31'b0, HWRITE}, {31'b0, v.wr});
    HREADY = 1'b0;
    repeat (v.wa) begin
      step();
      chk("addr_wait_htrans", {30'b0, HTRANS}, 32'd2);
    end
    HREADY = 1'b1;
    step();
    chk("data_htrans", {30'b0, HTRANS}, 32'd0);
    chk("data_hsel",   {31'b0, HSEL}, 32'd0);
    hw = HWDATA;
    if (v.wr) chk("data_hwdata", HWDATA, v.wdata);
    HRESP  = v.resp;
    HRDATA = v.wr ? 32'hBAD0_BAD0 : (mem.exists(v.exp_haddr) ? mem[v.exp_haddr] : 32'h0);
    HREADY = 1'b0;
    repeat (v.wd) begin
      step();
      chk("wait_htrans", {30'b0, HTRANS}, 32'd0);
      chk("wait_hwdata", HWDATA, hw);
      chk("wait_rspv",   {31'b0, rsp0_valid | rsp1_valid}, 32'd0);
    end
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    if (v.wr && !v.resp) mem[v.exp_haddr] = v.wdata;
    chk("done_rspv", {31'b0, (v.n == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
    chk("idle_htrans", {30'b0, HTRANS}, 32'd0);
    chk("idle_haddr_hold", HADDR, v.exp_haddr);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    // n, wr, addr, wdata, wa, wd, resp, exp_rdata, exp_haddr
    vecs[0] = '{0, 1'b1, 32'h0,  32'hA5A5_A5A5, 0, 0, 1'b0, 32'h0,         32'h0};
    vecs[1] = '{0, 1'b0, 32'h0,  32'h0,         0, 0, 1'b0, 32'hA5A5_A5A5, 32'h0};
    vecs[2] = '{1, 1'b1, 32'h4,  32'h1234_5678, 0, 0, 1'b0, 32'h0,         32'h4};
    vecs[3] = '{1, 1'b0, 32'h6,  32'h0,         0, 0, 1'b0, 32'h1234_5678, 32'h4};
    vecs[4] = '{0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'h0,         32'h10};
    vecs[5] = '{1, 1'b0, 32'h13, 32'h0,         2, 1, 1'b0, 32'hDEAD_BEEF, 32'h10};
    vecs[6] = '{0, 1'b1, 32'h8,  32'h5555_0000, 0, 1, 1'b1, 32'h0,         32'h8};
    vecs[7] = '{1, 1'b0, 32'hC,  32'h0,         0, 0, 1'b0, 32'h0,         32'hC};

    #3;
    chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst_hsel",   {31'b0, HSEL}, 32'd0);
    chk("rst_haddr",  HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hwrite", {31'b0, HWRITE}, 32'd0);
    chk("rst_rdata",  rsp_rdata, 32'd0);
    chk("rst_err",    {31'b0, rsp_err}, 32'd0);
    chk("rst_rspv",   {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("const_ctl",  {20'b0, HSIZE, HBURST, HPROT}, {20'b0, 3'b010, 3'b000, 4'b0011});
    step();
    HRESET = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: last grant was requester 1, so order is 0,1,0,1.
    req0_addr = 32'h20; req0_write = 1'b1; req0_wdata = 32'h0000_0020;
    req1_addr = 32'h24; req1_write = 1'b1; req1_wdata = 32'h0000_0024;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    HREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", {31'b0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", {31'b0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      e.n = k % 2; e.rdata = model_rdata; e.err = 1'b0;
      sb.push_back(e);
      step();
      chk("rr_haddr", HADDR, (k % 2 == 0) ? 32'h20 : 32'h24);
      step();
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    step();

    // A request withdrawn while busy is never granted.
    req0_valid = 1'b1; req0_addr = 32'h40; req0_write = 1'b1; req0_wdata = 32'h4040_4040;
    #1;
    e.n = 0; e.rdata = model_rdata; e.err = 1'b0;
    sb.push_back(e);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 32'h50; req1_write = 1'b0;
    #1;
    chk("busy_ready1", {31'b0, req1_ready}, 32'd0);
    step();
    req1_valid = 1'b0;
    step();
    chk("wd_rsp0", {31'b0, rsp0_valid}, 32'd1);
    step();
    chk("wd_no_xfer", {30'b0, HTRANS}, 32'd0);

    // Reset during DATA: requester 1 lone write, abandoned.
    req1_valid = 1'b1; req1_addr = 32'h30; req1_write = 1'b1; req1_wdata = 32'h0000_0077;
    step();
    req1_valid = 1'b0;
    step();
    HREADY = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    chk("mid_rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("mid_rst_hsel",   {31'b0, HSEL}, 32'd0);
    chk("mid_rst_haddr",  HADDR, 32'd0);
    chk("mid_rst_hwdata", HWDATA, 32'd0);
    chk("mid_rst_hwrite", {31'b0, HWRITE}, 32'd0);
    chk("mid_rst_rdata",  rsp_rdata, 32'd0);
    chk("mid_rst_rspv",   {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    HREADY = 1'b1;
    step();
    HRESET = 1'b0;
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_tie0", {31'b0, req0_ready}, 32'd1);
    chk("post_rst_tie1", {31'b0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
